// File: rtl/onebit_frame_sched.sv
// Frame sequencer for the one-bit complex datapath: gates one frame of samples
// into the datapath, collects its outputs with a timeout and reports the peak.
module onebit_frame_sched #(
  parameter int unsigned FW        = 16,
  parameter int unsigned DW        = 32,
  parameter int unsigned FLUSH_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [FW-1:0] frame_len,
  output logic          busy,
  input  logic          s_valid,
  input  logic          s_re,
  input  logic          s_im,
  output logic          s_ready,
  output logic          dp_en,
  output logic          dp_x_re,
  output logic          dp_x_im,
  input  logic          dp_valid,
  input  logic [DW-1:0] dp_y_re,
  input  logic [DW-1:0] dp_y_im,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [DW:0]   r_peak,
  output logic [FW-1:0] r_peak_idx,
  output logic [FW-1:0] r_out_cnt,
  output logic          r_err
);

  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_REPORT
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] len_q, len_d;
  logic [FW-1:0] in_cnt_q, in_cnt_d;
  logic [FW-1:0] out_cnt_q, out_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [FW-1:0] peak_idx_q, peak_idx_d;
  logic [DW:0]   peak_q, peak_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          dp_en_q, dp_en_d;
  logic          dp_x_re_q, dp_x_re_d;
  logic          dp_x_im_q, dp_x_im_d;
  logic          r_valid_q, r_valid_d;
  logic          r_err_q, r_err_d;

  logic [DW:0]   ext_re, ext_im, abs_re, abs_im, mag;
  logic          accept, capture;

  assign s_ready = (state_q == S_RUN);
  assign accept  = s_valid && (state_q == S_RUN);
  assign capture = dp_valid && ((state_q == S_RUN) || (state_q == S_FLUSH));

  // Magnitude in DW+1 bits so that |-2^(DW-1)| is exact.
  always_comb begin
    ext_re = {dp_y_re[DW-1], dp_y_re};
    ext_im = {dp_y_im[DW-1], dp_y_im};
    abs_re = dp_y_re[DW-1] ? (~ext_re + (DW+1)'(1)) : ext_re;
    abs_im = dp_y_im[DW-1] ? (~ext_im + (DW+1)'(1)) : ext_im;
    mag    = abs_re + abs_im;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_cnt_d = flush_cnt_q;
    peak_idx_d  = peak_idx_q;
    peak_d      = peak_q;
    err_d       = err_q;
    dp_en_d     = 1'b0;
    dp_x_re_d   = dp_x_re_q;
    dp_x_im_d   = dp_x_im_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d      = frame_len;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          peak_d     = '0;
          peak_idx_d = '0;
          err_d      = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          dp_en_d   = 1'b1;
          dp_x_re_d = s_re;
          dp_x_im_d = s_im;
          in_cnt_d  = in_cnt_q + FW'(1);
          if ((in_cnt_q + FW'(1)) == len_q) begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if ((out_cnt_q == len_q) || (flush_cnt_q == FLUSH_LAST)) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (r_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs beyond the frame length are dropped but flagged.
    if (capture) begin
      if (out_cnt_q < len_q) begin
        if (mag > peak_q) begin
          peak_d     = mag;
          peak_idx_d = out_cnt_q;
        end
        out_cnt_d = out_cnt_q + FW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    busy_d    = (state_d != S_IDLE);
    r_valid_d = (state_d == S_REPORT);
    r_err_d   = (state_d == S_REPORT) ? (err_d | (out_cnt_d != len_q)) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      peak_idx_q  <= '0;
      peak_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      dp_en_q     <= 1'b0;
      dp_x_re_q   <= 1'b0;
      dp_x_im_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      r_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      peak_idx_q  <= peak_idx_d;
      peak_q      <= peak_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      dp_en_q     <= dp_en_d;
      dp_x_re_q   <= dp_x_re_d;
      dp_x_im_q   <= dp_x_im_d;
      r_valid_q   <= r_valid_d;
      r_err_q     <= r_err_d;
    end
  end

  assign busy       = busy_q;
  assign dp_en      = dp_en_q;
  assign dp_x_re    = dp_x_re_q;
  assign dp_x_im    = dp_x_im_q;
  assign r_valid    = r_valid_q;
  assign r_peak     = peak_q;
  assign r_peak_idx = peak_idx_q;
  assign r_out_cnt  = out_cnt_q;
  assign r_err      = r_err_q;

endmodule

// File: tb/tb_onebit_frame_sched.sv
// Bench for onebit_frame_sched: a datapath model feeds outputs back and a
// scoreboard of expected frame results is compared on each r_valid.
module tb_onebit_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] frame_len;
  logic        busy, s_valid, s_re, s_im, s_ready;
  logic        dp_en, dp_x_re, dp_x_im, dp_valid;
  logic [31:0] dp_y_re, dp_y_im;
  logic        r_valid, r_ready, r_err;
  logic [32:0] r_peak;
  logic [15:0] r_peak_idx, r_out_cnt;

  typedef struct packed {
    logic [32:0] peak;
    logic [15:0] idx;
    logic [15:0] cnt;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    bit          drop;
  } resp_t;

  resp_t      resp_q[$];
  res_t       exp_q[$];
  logic [2:0] en_log[$];
  int         extra_n = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  onebit_frame_sched #(.FW(16), .DW(32), .FLUSH_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .busy(busy),
    .s_valid(s_valid), .s_re(s_re), .s_im(s_im), .s_ready(s_ready),
    .dp_en(dp_en), .dp_x_re(dp_x_re), .dp_x_im(dp_x_im),
    .dp_valid(dp_valid), .dp_y_re(dp_y_re), .dp_y_im(dp_y_im),
    .r_valid(r_valid), .r_ready(r_ready), .r_peak(r_peak),
    .r_peak_idx(r_peak_idx), .r_out_cnt(r_out_cnt), .r_err(r_err)
  );

  // Datapath model: one output per enable, a fixed pipeline later, optional extra.
  initial begin
    logic [2:0] pipe;
    bit         extra_next;
    resp_t      r;
    pipe = '0; extra_next = 0;
    dp_valid = 1'b0; dp_y_re = '0; dp_y_im = '0;
    forever begin
      @(negedge clk);
      pipe = {pipe[1:0], dp_en};
      dp_valid = 1'b0;
      if (pipe[2] && (resp_q.size() > 0)) begin
        r = resp_q.pop_front();
        if (!r.drop) begin
          dp_valid = 1'b1; dp_y_re = r.re; dp_y_im = r.im;
        end
        if ((resp_q.size() == 0) && (extra_n > 0)) extra_next = 1;
      end else if (extra_next) begin
        dp_valid = 1'b1; dp_y_re = 32'd1; dp_y_im = 32'd1;
        extra_next = 0; extra_n = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic resp_t mk(input int re, input int im, input bit drop);
    resp_t r;
    r.re = 32'(re); r.im = 32'(im); r.drop = drop;
    return r;
  endfunction

  function automatic longint absv(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  // Reference model of a frame result, computed from the programmed responses.
  task automatic expect_frame(input int len);
    longint pk = 0, m;
    int     idx = 0, cnt = 0;
    bit     e = 0;
    res_t   x;
    foreach (resp_q[i]) begin
      if (!resp_q[i].drop) begin
        if (cnt < len) begin
          m = absv(resp_q[i].re) + absv(resp_q[i].im);
          if (m > pk) begin pk = m; idx = cnt; end
          cnt++;
        end else e = 1;
      end
    end
    for (int k = 0; k < extra_n; k++) begin
      if (cnt < len) begin
        if (longint'(2) > pk) begin pk = 2; idx = cnt; end
        cnt++;
      end else e = 1;
    end
    if (cnt != len) e = 1;
    x.peak = 33'(pk); x.idx = 16'(idx); x.cnt = 16'(cnt); x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic build_en_exp(input int n, input int len, input logic [15:0] v, re, im,
                              output logic [2:0] q[$]);
    int cnt = 0;
    bit acc;
    q.delete();
    for (int i = 0; i < n; i++) begin
      acc = v[i] && (cnt < len);
      if (acc) cnt++;
      q.push_back({acc, re[i], im[i]});
    end
  endtask

  task automatic start_frame(input logic [15:0] len);
    @(negedge clk); start = 1'b1; frame_len = len;
    @(negedge clk); start = 1'b0; frame_len = '0;
  endtask

  task automatic drive_samples(input int n, input logic [15:0] v, re, im);
    en_log.delete();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      en_log.push_back({dp_en, dp_x_re, dp_x_im});
      s_valid = (i < n) ? v[i] : 1'b0;
      s_re    = (i < n) ? re[i] : 1'b0;
      s_im    = (i < n) ? im[i] : 1'b0;
    end
  endtask

  task automatic wait_result(output res_t obs, output bit to);
    to = 1; obs = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r_valid) begin
        obs = {r_peak, r_peak_idx, r_out_cnt, r_err};
        to = 0;
        break;
      end
    end
  endtask

  task automatic ack_result();
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, s_ready, r_valid, r_err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy/s_ready/r_valid/r_err=%b required 0000", {busy, s_ready, r_valid, r_err});
    end
    checks++;
    if ({dp_en, dp_x_re, dp_x_im} !== 3'b0) begin
      errors++; $display("FAIL reset_dp: got en/re/im=%b required 000", {dp_en, dp_x_re, dp_x_im});
    end
    checks++;
    if ({r_peak, r_peak_idx, r_out_cnt} !== 65'b0) begin
      errors++; $display("FAIL reset_result: got peak=%h idx=%h cnt=%h required all 0", r_peak, r_peak_idx, r_out_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] eq[$];
    res_t obs, x;
    bit to;
    resp_q = '{mk(5, -3, 0), mk(-10, 2, 0), mk(7, 7, 0), mk(0, 0, 0)};
    expect_frame(4);
    build_en_exp(6, 4, 16'b001111, 16'b000101, 16'b000110, eq);
    start_frame(16'd4);
    drive_samples(6, 16'b001111, 16'b000101, 16'b000110);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (eq[i][2] ? (en_log[i+1] !== eq[i]) : (en_log[i+1][2] !== 1'b0)) begin
        errors++; $display("FAIL basic_dp cycle %0d: got en/re/im=%b required %b", i, en_log[i+1], eq[i]);
      end
    end
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL basic_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL basic_result: got %h required %h", obs, x); end
    ack_result();
  endtask

  task automatic test_gaps();
    logic [2:0] eq[$];
    res_t obs, x;
    bit to;
    int nen = 0;
    resp_q = '{mk(3, 4, 0), mk(-1, -1, 0), mk(2, 2, 0)};
    expect_frame(3);
    build_en_exp(7, 3, 16'b0011001, 16'b0010011, 16'b0001001, eq);
    start_frame(16'd3);
    drive_samples(7, 16'b0011001, 16'b0010011, 16'b0001001);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL gaps_s_ready: got %b required 0 after last accept", s_ready); end
    for (int i = 0; i < 7; i++) begin
      if (en_log[i+1][2] === 1'b1) nen++;
      checks++;
      if (eq[i][2] ? (en_log[i+1] !== eq[i]) : (en_log[i+1][2] !== 1'b0)) begin
        errors++; $display("FAIL gaps_dp cycle %0d: got en/re/im=%b required %b", i, en_log[i+1], eq[i]);
      end
    end
    checks++;
    if (nen != 3) begin errors++; $display("FAIL gaps_en_count: got %0d required 3", nen); end
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL gaps_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL gaps_result: got %h required %h", obs, x); end
    ack_result();
  endtask

  task automatic test_count_err();
    res_t obs, x;
    bit to;
    resp_q = '{mk(1, 1, 0), mk(2, 2, 1), mk(3, 3, 0), mk(4, 4, 0)};
    expect_frame(4);
    start_frame(16'd4);
    drive_samples(4, 16'b1111, 16'b1010, 16'b0101);
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL drop_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL drop_result: got %h required %h", obs, x); end
    ack_result();
    resp_q = '{mk(6, 0, 0), mk(1, 0, 0), mk(0, -6, 0), mk(2, 2, 0)};
    extra_n = 1;
    expect_frame(4);
    start_frame(16'd4);
    drive_samples(4, 16'b1111, 16'b0011, 16'b1100);
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL extra_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL extra_result: got %h required %h", obs, x); end
    ack_result();
  endtask

  task automatic test_magnitude();
    res_t obs, x;
    bit to;
    resp_q = '{mk(32'h8000_0000, 32'h8000_0000, 0), mk(5, 5, 0)};
    expect_frame(2);
    start_frame(16'd2);
    drive_samples(2, 16'b11, 16'b01, 16'b10);
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL extreme_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL extreme_result: got %h required %h", obs, x); end
    ack_result();
    resp_q = '{mk(4, -5, 0), mk(-20, 0, 0), mk(1, 2, 0), mk(10, -10, 0)};
    expect_frame(4);
    start_frame(16'd4);
    drive_samples(4, 16'b1111, 16'b1001, 16'b0110);
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL tie_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL tie_result: got %h required %h", obs, x); end
    ack_result();
  endtask

  task automatic test_report_hold();
    res_t obs, x;
    bit to;
    resp_q = '{mk(3, -4, 0)};
    expect_frame(1);
    start_frame(16'd1);
    drive_samples(2, 16'b01, 16'b01, 16'b00);
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL hold_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL hold_result: got %h required %h", obs, x); end
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); frame_len = 16'd3;
      @(negedge clk);
      checks++;
      if ({r_valid, busy, r_peak, r_peak_idx, r_out_cnt, r_err} !== {2'b11, x}) begin
        errors++; $display("FAIL hold_stable cycle %0d: got v=%b busy=%b res=%h required v=1 busy=1 res=%h",
                           k, r_valid, busy, {r_peak, r_peak_idx, r_out_cnt, r_err}, x);
      end
    end
    start = 1'b0; frame_len = '0;
    ack_result();
    checks++;
    if ({r_valid, busy} !== 2'b00) begin errors++; $display("FAIL hold_release: got r_valid/busy=%b required 00", {r_valid, busy}); end
    start_frame(16'd0);
    @(negedge clk);
    checks++;
    if ({busy, s_ready} !== 2'b00) begin errors++; $display("FAIL zero_len: got busy/s_ready=%b required 00", {busy, s_ready}); end
  endtask

  task automatic test_reset_mid_frame();
    res_t obs, x;
    bit to;
    resp_q.delete(); extra_n = 0;
    start_frame(16'd4);
    drive_samples(2, 16'b11, 16'b01, 16'b10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dp_en, busy, r_valid} !== 3'b000) begin
      errors++; $display("FAIL midreset: got dp_en/busy/r_valid=%b required 000", {dp_en, busy, r_valid});
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    resp_q = '{mk(2, 3, 0), mk(-1, 1, 0)};
    expect_frame(2);
    start_frame(16'd2);
    drive_samples(3, 16'b011, 16'b001, 16'b010);
    wait_result(obs, to); x = exp_q.pop_front(); checks++;
    if (to) begin errors++; $display("FAIL after_reset_result: got no r_valid in 200 cycles, required r_valid=1"); end
    else if (obs !== x) begin errors++; $display("FAIL after_reset_result: got %h required %h", obs, x); end
    ack_result();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_len = '0;
    s_valid = 1'b0; s_re = 1'b0; s_im = 1'b0; r_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_count_err();
    test_magnitude();
    test_report_hold();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onebit_frame_sched.md
Name: onebit_frame_sched

Overview:
Frame sequencer for the one-bit complex parallel datapath (x_re/x_im/en in, y_re/y_im/valid out). It accepts a stream of 1-bit complex samples, gates exactly one frame of frame_len samples into the datapath, and waits for the matching outputs with a timeout. Per frame it reports peak magnitude |y_re|+|y_im|, the index of the peak, the output count and an error flag over a valid/ready result port. Sits between the sample source and the datapath; the result port feeds the detection/control logic.

Parameters:
FW, 16, width of frame length, index and counters
DW, 32, datapath output width (signed)
FLUSH_CYC, 8, max cycles waited in FLUSH for outstanding datapath outputs (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle frame start request
frame_len  in  FW  samples per frame, latched on accepted start
busy  out  1  high in RUN/FLUSH/REPORT
s_valid  in  1  input sample valid
s_re  in  1  input sample real bit
s_im  in  1  input sample imaginary bit
s_ready  out  1  sample accept, combinational = (state==RUN)
dp_en  out  1  datapath enable (registered)
dp_x_re  out  1  datapath real bit (registered)
dp_x_im  out  1  datapath imaginary bit (registered)
dp_valid  in  1  datapath output valid
dp_y_re  in  DW  datapath real output, signed
dp_y_im  in  DW  datapath imaginary output, signed
r_valid  out  1  frame result valid
r_ready  in  1  frame result accept
r_peak  out  DW+1  max |y_re|+|y_im| in frame, unsigned
r_peak_idx  out  FW  output index (0-based) of first max
r_out_cnt  out  FW  number of dp_valid outputs counted
r_err  out  1  r_out_cnt != frame_len, or extra outputs seen

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, s_ready, dp_en, dp_x_re, dp_x_im, r_valid, r_err = 0; r_peak, r_peak_idx, r_out_cnt = 0; all counters 0. Reset mid-frame aborts with no report.
- IDLE: start=1 and frame_len!=0 -> latch len, clear in_cnt/out_cnt/peak/peak_idx/err, go RUN. start with frame_len==0 ignored. start outside IDLE ignored.
- RUN: s_ready=1. Each s_valid&&s_ready cycle: next cycle dp_en=1, dp_x_re=s_re, dp_x_im=s_im (1-cycle latency); in_cnt++. Cycles with no accept: dp_en=0, dp_x_* hold. When the len-th sample is accepted -> FLUSH next cycle.
- FLUSH: s_ready=0, dp_en=0 from the cycle after the last sample. flush_cnt clears on entry and increments each cycle. Exit to REPORT when out_cnt==len (registered count) or flush_cnt==FLUSH_CYC-1.
- Output capture (RUN and FLUSH only; dp_valid ignored in IDLE/REPORT): mag = |dp_y_re|+|dp_y_im| in DW+1 bits; |-2^(DW-1)| = 2^(DW-1) exactly, no overflow. If out_cnt<len: if mag>peak (strict; first max wins) then peak=mag, peak_idx=out_cnt; out_cnt++. If out_cnt==len: output dropped, err=1.
- REPORT: r_valid=1; r_peak, r_peak_idx, r_out_cnt stable; r_err = err | (out_cnt!=len). Hold until r_valid&&r_ready, then IDLE; r_valid and busy low next cycle.
- busy = (state!=IDLE).

Test Plan:
- frame_len=4, continuous s_valid, samples (1,0),(0,1),(1,1),(0,0); datapath model returns valid 3 cycles after each dp_en with (5,-3),(-10,2),(7,7),(0,0) -> dp_en high 4 consecutive cycles starting 1 cycle after first accept, dp_x_* match; r_peak=14, r_peak_idx=2, r_out_cnt=4, r_err=0.
- frame_len=3, s_valid pattern 1,0,0,1,1 -> dp_en pattern 1,0,0,1,1 one cycle later; exactly 3 enables; s_ready=0 after third accept.
- frame_len=4, model drops the 2nd output -> FLUSH times out after FLUSH_CYC=8 cycles; r_out_cnt=3, r_err=1. Model emits 5 outputs -> r_out_cnt=4, r_err=1.
- Outputs (-2^31,-2^31) at idx 0 -> r_peak=0x1_0000_0000. Mags 9,20,3,20 -> r_peak=20, r_peak_idx=1.
- In REPORT hold r_ready=0 5 cycles and pulse start -> r_* stable, no new frame; then r_ready=1 -> IDLE, busy=0 next cycle. start with frame_len=0 -> stays IDLE.
- Assert rst_n=0 in RUN after 2 samples -> dp_en=0, busy=0, r_valid=0 immediately; after release, frame_len=2 frame completes normally with r_out_cnt=2.
